// File: rtl/ser_tx_ce.sv
// Parallel-to-serial transmitter with clock enable: one WIDTH-bit word per valid/ready
// handshake, one bit per enabled clock. Optional even parity bit via SER_TX_PARITY_EN.
module ser_tx_ce #(
  parameter int   WIDTH     = 8,
  parameter logic INIT      = 1'b0,
  parameter int   MSB_FIRST = 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VLD,
  output logic             DIN_RDY,
  output logic             Q,
  output logic             Q_VLD,
  output logic             LAST,
  output logic             BUSY
);

`ifdef SER_TX_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(FRAME - 2);

  typedef enum logic {IDLE, SHIFT} state_e;

  // Handshake: a word moves when CE & DIN_VLD & DIN_RDY at a rising edge of C.
  // DIN_RDY depends only on state and R, never on DIN_VLD or DIN.
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             q_q, q_d;
  logic             q_vld_q, q_vld_d;
  logic             last_q, last_d;
`ifdef SER_TX_PARITY_EN
  logic             par_q, par_d;
`endif
  logic             end_of_frame;
  logic             accept;

  assign end_of_frame = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign DIN_RDY      = !R && ((state_q == IDLE) || end_of_frame);
  assign accept       = CE && DIN_VLD && DIN_RDY;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    q_d     = q_q;
    q_vld_d = q_vld_q;
    last_d  = last_q;
`ifdef SER_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (CE) begin
      if (accept) begin
        // Loading puts the first bit on Q at the same edge.
        state_d = SHIFT;
        cnt_d   = '0;
        sreg_d  = DIN;
        q_d     = (MSB_FIRST != 0) ? DIN[WIDTH-1] : DIN[0];
        q_vld_d = 1'b1;
        last_d  = 1'b0;
`ifdef SER_TX_PARITY_EN
        par_d   = ^DIN;
`endif
      end else if (end_of_frame) begin
        state_d = IDLE;
        cnt_d   = '0;
        q_d     = INIT;
        q_vld_d = 1'b0;
        last_d  = 1'b0;
      end else if (state_q == SHIFT) begin
        cnt_d  = cnt_q + 1'b1;
        last_d = (cnt_q == CNT_PRE);
        if (MSB_FIRST != 0) begin
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
          q_d    = sreg_q[WIDTH-2];
        end else begin
          sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
          q_d    = sreg_q[1];
        end
`ifdef SER_TX_PARITY_EN
        if (cnt_q == CW'(WIDTH - 1)) q_d = par_q;
`endif
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      q_q     <= INIT;
      q_vld_q <= 1'b0;
      last_q  <= 1'b0;
`ifdef SER_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
      last_q  <= last_d;
`ifdef SER_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Q     = q_q;
  assign Q_VLD = q_vld_q;
  assign LAST  = last_q;
  assign BUSY  = (state_q == SHIFT);

endmodule

// File: tb/tb_ser_tx_ce.sv
// Bench for ser_tx_ce (WIDTH=8, INIT=0, MSB_FIRST=1): constant vector table, hand
// sequences for multi-cycle corners, and randomized traffic against a bit-queue model.
module tb_ser_tx_ce;
  localparam int   WIDTH     = 8;
  localparam logic INIT      = 1'b0;
  localparam int   MSB_FIRST = 1;

  logic             clk = 1'b0;
  logic             rst, ce, din_vld;
  logic [WIDTH-1:0] din;
  logic             din_rdy, q, q_vld, last, busy;

  int n_cmp = 0;
  int n_err = 0;

  // Bits still to appear on Q; front is the bit currently shown.
  logic exp_q[$];
  logic rdy_seen;
  logic acc_seen;

  ser_tx_ce #(.WIDTH(WIDTH), .INIT(INIT), .MSB_FIRST(MSB_FIRST)) dut (
    .C(clk), .R(rst), .CE(ce), .DIN(din), .DIN_VLD(din_vld), .DIN_RDY(din_rdy),
    .Q(q), .Q_VLD(q_vld), .LAST(last), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++)
      exp_q.push_back((MSB_FIRST != 0) ? w[WIDTH-1-i] : w[i]);
`ifdef SER_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  // Called just after a falling edge: apply inputs, check DIN_RDY, advance one
  // rising edge, update the model, then check the registered outputs.
  task automatic drive(input logic r_i, input logic ce_i, input logic vld_i,
                       input logic [WIDTH-1:0] d_i);
    logic exp_rdy;
    rst = r_i; ce = ce_i; din_vld = vld_i; din = d_i;
    #1;
    exp_rdy  = !r_i && (exp_q.size() <= 1);
    rdy_seen = din_rdy;
    check("din_rdy", din_rdy, exp_rdy);
    @(posedge clk);
    acc_seen = 1'b0;
    if (r_i) begin
      exp_q.delete();
    end else if (ce_i) begin
      acc_seen = vld_i && exp_rdy;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc_seen) push_frame(d_i);
    end
    @(negedge clk);
    check("q",     q,     (exp_q.size() > 0) ? exp_q[0] : INIT);
    check("q_vld", q_vld, exp_q.size() > 0);
    check("last",  last,  exp_q.size() == 1);
    check("busy",  busy,  exp_q.size() > 0);
  endtask

  typedef struct {
    logic r, c, v;
    logic [WIDTH-1:0] d;
    logic e_rdy, e_q, e_vld, e_last, e_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic c, input logic v, input logic [WIDTH-1:0] d,
                     input logic e_rdy, input logic e_q, input logic e_vld,
                     input logic e_last, input logic e_busy);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.d = d;
    t.e_rdy = e_rdy; t.e_q = e_q; t.e_vld = e_vld; t.e_last = e_last; t.e_busy = e_busy;
    tbl.push_back(t);
  endtask

  initial begin
    logic             hold_q;
    logic             rv_vld;
    logic [WIDTH-1:0] rv_din;
    rst = 1'b1; ce = 1'b1; din_vld = 1'b0; din = '0;

    //      r  ce v  din    rdy q  vld last busy
    add(1, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(1, 1, 0, 8'h00, 0, 0, 0, 0, 0);
`ifndef SER_TX_PARITY_EN
    add(0, 1, 1, 8'hA5, 1, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 1, 1);
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 0);
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 0);
`else
    add(0, 1, 1, 8'h07, 1, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 1, 1);
    add(0, 1, 1, 8'h03, 1, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 1, 1, 0, 1);
    add(0, 1, 0, 8'h00, 0, 0, 1, 1, 1);
    add(0, 1, 0, 8'h00, 1, 0, 0, 0, 0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].d);
      check("tbl_rdy",  rdy_seen, tbl[i].e_rdy);
      check("tbl_q",    q,        tbl[i].e_q);
      check("tbl_vld",  q_vld,    tbl[i].e_vld);
      check("tbl_last", last,     tbl[i].e_last);
      check("tbl_busy", busy,     tbl[i].e_busy);
    end

    // Back-to-back words: Q_VLD must stay high across the frame boundary.
    drive(0, 1, 1, 8'h3C);
    for (int i = 0; i < 2 * WIDTH - 1; i++) begin
      if (i < WIDTH) drive(0, 1, 1, 8'hC3);
      else           drive(0, 1, 0, 8'h00);
      check("b2b_vld", q_vld, 1'b1);
    end
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'h00);

    // Clock enable toggling mid-frame: outputs hold while CE is low.
    drive(0, 1, 1, 8'hA5);
    for (int i = 0; i < 24; i++) begin
      hold_q = q;
      if ((i % 3) != 0) begin
        drive(0, 0, 0, 8'h00);
        check("ce_hold", q, hold_q);
      end else begin
        drive(0, 1, 0, 8'h00);
      end
    end
    drive(0, 1, 0, 8'h00);

    // Reset in the middle of a frame, then a clean frame afterwards.
    drive(0, 1, 1, 8'hFF);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'h00);
    drive(1, 1, 0, 8'h00);
    check("abort_vld", q_vld, 1'b0);
    drive(0, 1, 1, 8'h01);
    for (int i = 0; i < WIDTH + 2; i++) drive(0, 1, 0, 8'h00);

    // Randomized traffic; a word offered stays put until it is accepted.
    rv_vld = 1'b0; rv_din = '0; acc_seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!rv_vld || acc_seen) begin
        rv_vld = ($urandom_range(0, 2) != 0);
        rv_din = WIDTH'($urandom);
      end
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), rv_vld, rv_din);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
